lsu_ctrl: RTL
=============

# lsu_ctrl

Load/store sequencing controller between the core's memory stage and the data-memory bus. Accepts one load or store per request, forms a word-aligned bus transaction with byte enables and lane-replicated store data, and holds it until the memory acknowledges. Returned load data is shifted by the byte offset and sign- or zero-extended per funct3. The result is presented to writeback with a one-cycle done pulse. Variable bus latency is absorbed here; the pipeline stalls on `reqReady`.

## Interface
- `ADDR_WIDTH`, default 32: byte-address width of `reqAddr` and `memAddr`.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `reqValid`  in  1  pipeline request valid.
- `reqReady`  out  1  high only in IDLE; a request transfers when `reqValid && reqReady`.
- `reqWrite`  in  1  1 = store, 0 = load.
- `reqFunct3`  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- `reqAddr`  in  ADDR_WIDTH  byte address.
- `reqWdata`  in  32  store data, right-justified.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  extended load data; valid while `done` is high.
- `fault`  out  1  one-cycle pulse: illegal or misaligned request, with no bus access.
- `memReq`  out  1  bus request, held until acknowledged.
- `memWe`  out  1  bus write enable.
- `memAddr`  out  ADDR_WIDTH  word-aligned address; bits [1:0] are 0.
- `memBe`  out  4  byte enables.
- `memWdata`  out  32  lane-replicated store data.
- `memAck`  in  1  bus acknowledge; completes the transaction in the same cycle.
- `memRdata`  in  32  read data, valid when `memAck` is high.

## Operation

States: IDLE, BUS, RESP.

- **IDLE.** `reqReady=1`. On transfer, latch `off = reqAddr[1:0]`, funct3, write flag and address.
  - If the request is legal: next state BUS, and drive the bus registers.
  - If it is illegal or misaligned: next state RESP with the fault flag set.
- **BUS.** `memReq=1`, and all `mem*` outputs stay stable.
  - On `memAck=1`: capture the extended load data (loads only) and go to RESP.
  - Otherwise stay in BUS. There is no timeout.
- **RESP.** `done=1`. `fault` reflects the latched fault flag. Next state is always IDLE.

Request legality:
- Illegal funct3: 011, 110, 111, and 100 or 101 with `reqWrite=1`.
- Misalignment is controlled by `LSU_MISALIGN_TRAP_EN` (see Configuration).

Byte enables and store data:
- B: `memBe = 4'b0001 << off`, `memWdata = {4{reqWdata[7:0]}}`.
- H: `memBe = 4'b0011 << off`, `memWdata = {2{reqWdata[15:0]}}`.
- W: `memBe = 4'b1111`, `memWdata = reqWdata`.
- Loads drive the same `memBe` as the equivalent store size, with `memWe=0`.

Load extension:
- First compute `sh = memRdata >> (8*off)`.
- LB/LBU extend `sh[7:0]`; LH/LHU extend `sh[15:0]`; LW passes `sh` through.
- LB and LH sign-extend; LBU and LHU zero-extend.
- For stores and faults, `rdata = 0`.

## Timing
- **Reset values.** State IDLE, `reqReady=1`, and `done`, `fault`, `memReq`, `memWe`, `memAddr`, `memBe`, `memWdata`, `rdata` all 0.
- **Reset mid-operation.** `rst` during BUS drops `memReq` at that edge. The request is abandoned with no `done`, and any later `memAck` is ignored in IDLE.
- **Latency.** Transfer at edge N puts `memReq=1` from cycle N+1. An ack sampled at edge M gives `done=1` during cycle M+1. The minimum is 3 cycles from transfer to the next `reqReady`.
- **Fault path.** Transfer at edge N gives `fault=done=1` during cycle N+1. `memReq` is never asserted.
- **Acknowledge handling.** `memAck` outside BUS is ignored.
- **Back-to-back requests.** A new request cannot transfer in the RESP cycle because `reqReady=0` there.
- **Hold requirement.** `reqReady` is low in BUS and RESP; the pipeline holds its inputs while stalled.

## Configuration
- **`LSU_MISALIGN_TRAP_EN` defined:**
  - An H access with `off[0]=1` is a fault.
  - A W access with `off != 0` is a fault.
- **`LSU_MISALIGN_TRAP_EN` undefined:**
  - Misalignment is never a fault.
  - The offset is forced to size-alignment: H uses `off & 2`, W uses 0. Enables and extension then follow from the forced offset.
  - Illegal-funct3 faults still apply.

## Test plan
- **LB, negative byte.** `reqAddr=0x1003`, LB, `memRdata=0x80FF1234`, ack after 2 wait cycles → `memAddr=0x1000`, `memBe=1000`, `rdata=0xFFFFFF80`, `done` for 1 cycle.
- **LHU, upper half.** `reqAddr=0x2002`, LHU, `memRdata=0xBEEF0000`, immediate ack → `memBe=1100`, `rdata=0x0000BEEF`, `done` 2 cycles after transfer.
- **SB lane replication.** `reqAddr=0x11`, `reqWdata=0x123456AB` → `memWe=1`, `memAddr=0x10`, `memBe=0010`, `memWdata=0xABABABAB`, `rdata=0` at `done`.
- **Misaligned LW.** LW at `0x6`:
  - Macro defined → `fault=done=1` next cycle, `memReq` stays 0.
  - Macro undefined → `memAddr=0x4`, `memBe=1111`, normal `done`.
- **Illegal funct3.** funct3 110, and funct3 100 with `reqWrite=1` → `fault` pulse, no bus activity.
- **Reset in BUS.** `rst` high during BUS, then `memAck` one cycle later → `memReq=0` after the edge, no `done`, `reqReady=1`.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl - load/store sequencing controller between the core memory stage
// and the data-memory bus.
//
// Accepts one load or store per request, forms a word-aligned bus
// transaction (byte enables + lane-replicated store data), holds it until
// memAck, then presents the extended load data with a one-cycle done pulse.
// Illegal or misaligned requests skip the bus and return done with fault.
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  defined   -> misaligned H/W accesses fault
//                         undefined -> offset is forced to size alignment
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqValid/reqReady        request handshake (ready only in IDLE)
//   reqWrite, reqFunct3      store flag, access size/sign
//   reqAddr, reqWdata        byte address, right-justified store data
//   done, rdata, fault       completion pulse, extended load data, fault pulse
//   memReq, memWe, memAddr   bus request, write enable, word address
//   memBe, memWdata          byte enables, replicated store data
//   memAck, memRdata         bus acknowledge, read data
module lsu_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic [2:0]            reqFunct3,
    input  logic [ADDR_WIDTH-1:0] reqAddr,
    input  logic [31:0]           reqWdata,
    output logic                  done,
    output logic [31:0]           rdata,
    output logic                  fault,
    output logic                  memReq,
    output logic                  memWe,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [3:0]            memBe,
    output logic [31:0]           memWdata,
    input  logic                  memAck,
    input  logic [31:0]           memRdata
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t                state, stateNext;
    logic                  faultQ;
    logic [1:0]            offQ;
    logic [2:0]            funct3Q;
    logic [31:0]           rdataQ;
    logic                  memWeQ;
    logic [ADDR_WIDTH-1:0] memAddrQ;
    logic [3:0]            memBeQ;
    logic [31:0]           memWdataQ;

    logic                  xfer;
    logic                  illegalF3;
    logic                  misalign;
    logic                  isFault;
    logic [1:0]            effOff;
    logic [3:0]            beNext;
    logic [31:0]           wdataNext;

    // Shift the returned word down by the byte offset, then extend by funct3.
    function automatic logic [31:0] extendLoad(input logic [31:0] raw,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
        logic [31:0] sh;
        sh = raw >> {off, 3'b000};
        case (f3)
            3'b000:  extendLoad = {{24{sh[7]}}, sh[7:0]};
            3'b001:  extendLoad = {{16{sh[15]}}, sh[15:0]};
            3'b100:  extendLoad = {24'h0, sh[7:0]};
            3'b101:  extendLoad = {16'h0, sh[15:0]};
            default: extendLoad = sh;
        endcase
    endfunction

    assign xfer = reqValid && reqReady;

    // Request decode: legality, effective offset, enables and store lanes.
    always_comb begin
        illegalF3 = 1'b1;
        case (reqFunct3)
            3'b000, 3'b001, 3'b010: illegalF3 = 1'b0;
            3'b100, 3'b101:         illegalF3 = reqWrite;  // no unsigned stores
            default:                illegalF3 = 1'b1;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        misalign = ((reqFunct3[1:0] == 2'b01) && reqAddr[0]) ||
                   ((reqFunct3[1:0] == 2'b10) && (reqAddr[1:0] != 2'b00));
        effOff   = reqAddr[1:0];
    end
`else
    // Misalignment is silently fixed by rounding the offset down to the size.
    always_comb begin
        misalign = 1'b0;
        case (reqFunct3[1:0])
            2'b01:   effOff = {reqAddr[1], 1'b0};
            2'b10:   effOff = 2'b00;
            default: effOff = reqAddr[1:0];
        endcase
    end
`endif

    assign isFault = illegalF3 || misalign;

    always_comb begin
        case (reqFunct3[1:0])
            2'b00: begin
                beNext    = 4'b0001 << effOff;
                wdataNext = {4{reqWdata[7:0]}};
            end
            2'b01: begin
                beNext    = 4'b0011 << effOff;
                wdataNext = {2{reqWdata[15:0]}};
            end
            default: begin
                beNext    = 4'b1111;
                wdataNext = reqWdata;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (xfer) stateNext = isFault ? RESP : BUS;
            BUS:     if (memAck) stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Control outputs
    always_comb begin
        reqReady = (state == IDLE);
        memReq   = (state == BUS);
        done     = (state == RESP);
        fault    = (state == RESP) && faultQ;
    end

    // Request latch, bus registers and load capture
    always_ff @(posedge clk) begin
        if (rst) begin
            faultQ    <= 1'b0;
            offQ      <= 2'b00;
            funct3Q   <= 3'b000;
            rdataQ    <= 32'h0;
            memWeQ    <= 1'b0;
            memAddrQ  <= '0;
            memBeQ    <= 4'b0000;
            memWdataQ <= 32'h0;
        end else begin
            if (xfer) begin
                faultQ  <= isFault;
                offQ    <= effOff;
                funct3Q <= reqFunct3;
                rdataQ  <= 32'h0;  // stores and faults report zero
                if (!isFault) begin
                    memWeQ    <= reqWrite;
                    memAddrQ  <= {reqAddr[ADDR_WIDTH-1:2], 2'b00};
                    memBeQ    <= beNext;
                    memWdataQ <= wdataNext;
                end
            end
            if ((state == BUS) && memAck && !memWeQ)
                rdataQ <= extendLoad(memRdata, offQ, funct3Q);
        end
    end

    assign rdata    = rdataQ;
    assign memWe    = memWeQ;
    assign memAddr  = memAddrQ;
    assign memBe    = memBeQ;
    assign memWdata = memWdataQ;

endmodule
